// File: rtl/cache_lru_ctrl_pkg.sv
// Shared types and helpers for the true-LRU controller.
// Matrices are sized for the largest supported associativity; unused rows/columns stay zero.
package cache_lru_pkg;

  localparam int unsigned MAX_WAYS = 8;
  localparam int unsigned CNT_W    = $clog2(MAX_WAYS);

  typedef logic [MAX_WAYS-1:0] lru_row_t;
  typedef lru_row_t [MAX_WAYS-1:0] lru_mat_t;

  typedef enum logic [0:0] {
    LRU_IDLE  = 1'b0,
    LRU_FLUSH = 1'b1
  } lru_state_e;

  // Mark `way` most recent: its row becomes all ones, then its column is cleared.
  function automatic lru_mat_t lru_touch(input lru_mat_t m, input logic [CNT_W-1:0] way,
                                         input int unsigned ways);
    lru_mat_t r;
    r = m;
    for (int unsigned i = 0; i < MAX_WAYS; i++) begin
      r[way][i] = (i < ways) && (i != 32'(way));
      r[i][way] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] lru_popcount(input lru_row_t row);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < MAX_WAYS; i++) n = n + CNT_W'(row[i]);
    return n;
  endfunction

endpackage

// File: rtl/cache_lru_ctrl_if.sv
// Touch / query / flush bus between the cache FSM (master) and the LRU controller (slave).
interface cache_lru_ctrl_if #(
  parameter int unsigned WAYS = 4,
  parameter int unsigned SETS = 64
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);

  logic             touch_valid;
  logic             touch_ready;
  logic [IDX_W-1:0] touch_index;
  logic [WAY_W-1:0] touch_way;
  logic             query_valid;
  logic             query_ready;
  logic [IDX_W-1:0] query_index;
  logic             resp_valid;
  logic [WAY_W-1:0] resp_way;
  logic             flush_req;
  logic             busy;

  modport master (
    output touch_valid, touch_index, touch_way, query_valid, query_index, flush_req,
    input  touch_ready, query_ready, resp_valid, resp_way, busy
  );

  modport slave (
    input  touch_valid, touch_index, touch_way, query_valid, query_index, flush_req,
    output touch_ready, query_ready, resp_valid, resp_way, busy
  );
endinterface

// File: rtl/cache_lru_ctrl_victim_select.sv
// Combinational LRU victim pick: per-row popcount, then a pairwise min tree.
// Strict less-than keeps the lower-index operand on ties.
module lru_victim_select
  import cache_lru_pkg::*;
#(
  parameter int unsigned WAYS = 4
) (
  input  lru_mat_t                   mat,
  output logic [$clog2(WAYS)-1:0]    victim_c
);
  localparam int unsigned WAY_W = $clog2(WAYS);

  function automatic logic [WAY_W-1:0] pick_min(input lru_mat_t m);
    logic [WAY_W-1:0] cnt [WAYS];
    logic [WAY_W-1:0] idx [WAYS];
    for (int unsigned i = 0; i < WAYS; i++) begin
      cnt[i] = WAY_W'(lru_popcount(m[i]));
      idx[i] = WAY_W'(i);
    end
    for (int unsigned span = 1; span < WAYS; span = span * 2) begin
      for (int unsigned n = 0; n + span < WAYS; n = n + 2 * span) begin
        if (cnt[n+span] < cnt[n]) begin
          cnt[n] = cnt[n+span];
          idx[n] = idx[n+span];
        end
      end
    end
    return idx[0];
  endfunction

  assign victim_c = pick_min(mat);

endmodule

// File: rtl/cache_lru_ctrl.sv
// True-LRU state controller: per-index LRU matrices, touch/query handling, flush sweep.
// Optional macro CACHE_LRU_FWD_EN: same-cycle same-index query sees the post-touch matrix.
module cache_lru_ctrl
  import cache_lru_pkg::*;
#(
  parameter int unsigned WAYS = 4,
  parameter int unsigned SETS = 64
) (
  input logic             clk,
  input logic             rst_n,
  cache_lru_ctrl_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);

  localparam logic [0:0] IDLE  = 1'(LRU_IDLE);
  localparam logic [0:0] FLUSH = 1'(LRU_FLUSH);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [IDX_W-1:0] sweep_cnt;
  lru_mat_t         mem [SETS];

  logic             touch_fire_c;
  logic             query_fire_c;
  logic             sweep_last_c;
  lru_mat_t         query_mat_c;
  logic [WAY_W-1:0] victim_c;

  assign bus.touch_ready = (state == IDLE);
  assign bus.query_ready = (state == IDLE);
  assign bus.busy        = (state == FLUSH);

  assign touch_fire_c = bus.touch_valid && (state == IDLE);
  assign query_fire_c = bus.query_valid && (state == IDLE);
  assign sweep_last_c = (sweep_cnt == IDX_W'(SETS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.flush_req) state_nxt = FLUSH;
      FLUSH:   if (sweep_last_c)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              sweep_cnt <= '0;
    else if (state == FLUSH) sweep_cnt <= sweep_last_c ? '0 : sweep_cnt + IDX_W'(1);
  end

  // Matrix storage: flush clears one index per cycle; touches only land while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SETS; i++) mem[i] <= '0;
    end else if (state == FLUSH) begin
      mem[sweep_cnt] <= '0;
    end else if (touch_fire_c) begin
      mem[bus.touch_index] <= lru_touch(mem[bus.touch_index], CNT_W'(bus.touch_way), WAYS);
    end
  end

`ifdef CACHE_LRU_FWD_EN
  always_comb begin
    query_mat_c = mem[bus.query_index];
    if (touch_fire_c && (bus.touch_index == bus.query_index))
      query_mat_c = lru_touch(mem[bus.query_index], CNT_W'(bus.touch_way), WAYS);
  end
`else
  always_comb begin
    query_mat_c = mem[bus.query_index];
  end
`endif

  lru_victim_select #(.WAYS(WAYS)) u_victim (
    .mat      (query_mat_c),
    .victim_c (victim_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.resp_valid <= 1'b0;
      bus.resp_way   <= '0;
    end else begin
      bus.resp_valid <= query_fire_c;
      if (query_fire_c) bus.resp_way <= victim_c;
    end
  end

endmodule
